// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the round-robin bus arbiter.
//   state_t        arbiter FSM states (IDLE, ARB, XFER)
//   BUS_W          width of data_bus
//   RSVD_FIELD_*   bit range of the reserved-code field within a beat
//   RSVD_CODE      field value that must never reach data_bus
package bus_arb_pkg;
  localparam int BUS_W         = 32;
  localparam int RSVD_FIELD_HI = 6;
  localparam int RSVD_FIELD_LO = 5;
  localparam logic [1:0] RSVD_CODE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req      request vector
//   ptr      index with highest priority this round
//   win      one-hot winner (0 when no request)
//   win_idx  binary index of the winner
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      win_idx
);
  int c;

  // Scan from the farthest candidate back to ptr so the closest
  // requester at or after ptr is the last (winning) assignment.
  always_comb begin
    win     = '0;
    win_idx = '0;
    c       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        win     = '0;
        win[c]  = 1'b1;
        win_idx = IW'(c);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing data_bus among NUM_REQ requesters.
// A grant lasts up to MAX_BEATS beats or until the requester drops valid;
// priority then rotates to the index after the granted one.
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester beat valid, doubles as the bus request
//   req_data     per-requester beat data
//   req_ready    beat accepted from the granted requester
//   gnt          registered one-hot grant
//   data_bus     granted beat, forced to 0 whenever bus_valid is low
//   bus_valid    beat present on data_bus
//   bus_ready    downstream accepts the beat
//   rsvd_err     pulse when a reserved-code beat is consumed (filter build)
// Build option BUS_ARB_RSVD_FILTER_EN: reserved-code beats are consumed from
// the requester but never forwarded; without it data passes unmodified.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][BUS_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [BUS_W-1:0]               data_bus,
  output logic                           bus_valid,
  input  logic                           bus_ready,
  output logic                           rsvd_err
);
  localparam int         IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LAST = 8'(MAX_BEATS - 1);

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt, win;
  logic [IW-1:0]        gidx, gidx_nxt, ptr, ptr_nxt, win_idx;
  logic [7:0]           cnt, cnt_nxt;
  logic                 xfer, g_valid, take, fwd;
  logic [BUS_W-1:0]     g_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  assign xfer    = (state == XFER);
  assign g_valid = xfer && req_valid[gidx];
  assign g_data  = req_data[gidx];
  // A consumed beat counts even when the filter swallows it.
  assign take    = g_valid && bus_ready;

`ifdef BUS_ARB_RSVD_FILTER_EN
  logic g_rsvd;
  assign g_rsvd   = (g_data[RSVD_FIELD_HI:RSVD_FIELD_LO] == RSVD_CODE);
  assign fwd      = g_valid && !g_rsvd;
  assign rsvd_err = take && g_rsvd;
`else
  assign fwd      = g_valid;
  assign rsvd_err = 1'b0;
`endif

  assign bus_valid = fwd;
  assign data_bus  = fwd ? g_data : '0;
  // gnt is only non-zero in XFER, so this also blanks ready elsewhere.
  assign req_ready = gnt & {NUM_REQ{bus_ready}};

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (|req_valid) state_nxt = ARB;
      ARB: begin
        if (|req_valid) begin
          state_nxt = XFER;
          gnt_nxt   = win;
          gidx_nxt  = win_idx;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      XFER: begin
        // Release (no beat) or final beat of a full burst ends the grant.
        if (!g_valid || (take && cnt == LAST)) begin
          gnt_nxt   = '0;
          ptr_nxt   = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state_nxt = (|req_valid) ? ARB : IDLE;
        end else if (take) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      gidx  <= gidx_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter
// (NUM_REQ=4, MAX_BEATS=8). Inputs change 1 time unit after the rising edge
// and outputs are compared 1 unit later, well clear of the next edge.
module tb_bus_arbiter;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        req_valid = '0;
  logic [3:0][31:0]  req_data = '0;
  logic [3:0]        req_ready;
  logic [3:0]        gnt;
  logic [31:0]       data_bus;
  logic              bus_valid;
  logic              bus_ready = 1'b0;
  logic              rsvd_err;
  int                checks = 0;
  int                failures = 0;

  bus_arbiter #(.NUM_REQ(4), .MAX_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .gnt(gnt), .data_bus(data_bus),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .rsvd_err(rsvd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; bus_ready = 1'b0;
    tick(); #1;
    checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt act=%b exp=0000", gnt); end
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_bus_valid act=%b exp=0", bus_valid); end
    checks++; if (data_bus !== 32'h0) begin failures++; $display("FAIL reset_data_bus act=%h exp=0", data_bus); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready act=%b exp=0000", req_ready); end
    checks++; if (rsvd_err !== 1'b0) begin failures++; $display("FAIL reset_rsvd_err act=%b exp=0", rsvd_err); end
    rst_n = 1'b1;
    tick();
  endtask

  // Req 1 alone, three beats then release; then {1,3} proves ptr moved to 2.
  task automatic test_single();
    bus_ready = 1'b1; req_valid = 4'b0010; req_data[1] = 32'h11; #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle_gnt act=%b exp=0000", gnt); end
    tick(); #1;
    checks++; if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin failures++; $display("FAIL single_arb act=%b/%b exp=0000/0", gnt, bus_valid); end
    for (int k = 0; k < 3; k++) begin
      tick(); req_data[1] = 32'h11 + k; #1;
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL single_gnt%0d act=%b exp=0010", k, gnt); end
      checks++; if (bus_valid !== 1'b1 || data_bus !== 32'h11 + k) begin failures++; $display("FAIL single_beat%0d act=%b/%h exp=1/%h", k, bus_valid, data_bus, 32'h11 + k); end
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready%0d act=%b exp=0010", k, req_ready); end
    end
    tick(); req_valid = 4'b0000; #1;
    checks++; if (bus_valid !== 1'b0 || data_bus !== 32'h0) begin failures++; $display("FAIL single_release act=%b/%h exp=0/0", bus_valid, data_bus); end
    tick(); #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle_after act=%b exp=0000", gnt); end
    req_valid = 4'b1010; req_data[3] = 32'h33;
    tick(); tick(); #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL single_ptr2 act=%b exp=1000", gnt); end
    req_valid = 4'b0000;
    tick(); tick();   // release -> IDLE, ptr=0
  endtask

  // All four valid: grants 0,1,2,3,0 of exactly 8 beats, ARB cycle between.
  task automatic test_round_robin();
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    for (int i = 0; i < 4; i++) req_data[i] = 32'hA0 + i;
    bus_ready = 1'b1; req_valid = 4'b1111;
    tick();
    for (int b = 0; b < 5; b++) begin
      #1;
      checks++; if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin failures++; $display("FAIL rr_arb%0d act=%b/%b exp=0000/0", b, gnt, bus_valid); end
      tick();
      for (int k = 0; k < 8; k++) begin
        #1;
        checks++; if (gnt !== order[b]) begin failures++; $display("FAIL rr_gnt b%0d k%0d act=%b exp=%b", b, k, gnt, order[b]); end
        checks++; if (bus_valid !== 1'b1 || data_bus !== 32'hA0 + $clog2(order[b])) begin failures++; $display("FAIL rr_data b%0d k%0d act=%h exp=%h", b, k, data_bus, 32'hA0 + $clog2(order[b])); end
        tick();
      end
    end
    req_valid = 4'b0000;
    tick(); #1;   // ARB with nothing -> IDLE, ptr=1
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rr_idle act=%b exp=0000", gnt); end
  endtask

  // 2 beats, 5 stalled cycles, then exactly 6 more beats before exit.
  task automatic test_backpressure();
    req_valid = 4'b0100; req_data[2] = 32'h200; bus_ready = 1'b1;
    tick(); tick(); tick(); tick();   // ARB, XFER beat0, beat1 -> cnt=2
    bus_ready = 1'b0; req_data[2] = 32'h202;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++; if (gnt !== 4'b0100 || req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold%0d gnt=%b ready=%b exp=0100/0000", s, gnt, req_ready); end
      checks++; if (bus_valid !== 1'b1 || data_bus !== 32'h202) begin failures++; $display("FAIL bp_data%0d act=%b/%h exp=1/202", s, bus_valid, data_bus); end
      tick();
    end
    bus_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL bp_remain%0d act=%b exp=0100", k, gnt); end
      tick();
    end
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL bp_exit act=%b exp=0000", gnt); end
    req_valid = 4'b0000;
    tick();   // ARB -> IDLE, ptr=3
  endtask

  // ptr=3 with {0,2}: grant 0, then 2.
  task automatic test_wrap();
    req_valid = 4'b0101; req_data[0] = 32'h5; bus_ready = 1'b1;
    tick(); tick(); #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_first act=%b exp=0001", gnt); end
    req_valid = 4'b0100;
    tick(); tick(); #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL wrap_second act=%b exp=0100", gnt); end
    req_valid = 4'b0000;
    tick(); tick();   // IDLE, ptr=3
  endtask

  task automatic test_rsvd();
    req_valid = 4'b0001; req_data[0] = 32'h0000_0060; bus_ready = 1'b1;
    tick(); tick(); #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rsvd_ready act=%b exp=0001", req_ready); end
`ifdef BUS_ARB_RSVD_FILTER_EN
    checks++; if (bus_valid !== 1'b0 || data_bus !== 32'h0) begin failures++; $display("FAIL rsvd_filtered act=%b/%h exp=0/0", bus_valid, data_bus); end
    checks++; if (rsvd_err !== 1'b1) begin failures++; $display("FAIL rsvd_err_pulse act=%b exp=1", rsvd_err); end
`else
    checks++; if (bus_valid !== 1'b1 || data_bus !== 32'h60) begin failures++; $display("FAIL rsvd_pass act=%b/%h exp=1/60", bus_valid, data_bus); end
    checks++; if (rsvd_err !== 1'b0) begin failures++; $display("FAIL rsvd_err_tied act=%b exp=0", rsvd_err); end
`endif
    tick(); req_data[0] = 32'h1; #1;
    checks++; if (rsvd_err !== 1'b0 || bus_valid !== 1'b1 || data_bus !== 32'h1) begin failures++; $display("FAIL rsvd_next act=%b/%b/%h exp=0/1/1", rsvd_err, bus_valid, data_bus); end
    req_valid = 4'b0000;
    tick(); tick();   // IDLE, ptr=1
  endtask

  // Reset during beat 4 of req 1's burst; afterwards {0,1} must pick 0.
  task automatic test_reset_mid();
    req_valid = 4'b0010; req_data[1] = 32'hBEEF; bus_ready = 1'b1;
    tick(); tick();
    tick(); tick(); tick(); tick();   // beats 0..3 done, beat 4 on the bus
    #1;
    checks++; if (gnt !== 4'b0010 || bus_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre act=%b/%b exp=0010/1", gnt, bus_valid); end
    rst_n = 1'b0; #1;
    checks++; if (gnt !== 4'b0 || bus_valid !== 1'b0 || data_bus !== 32'h0 || req_ready !== 4'b0) begin failures++; $display("FAIL rstmid_outs gnt=%b v=%b d=%h r=%b exp=all0", gnt, bus_valid, data_bus, req_ready); end
    rst_n = 1'b1; req_valid = 4'b0011; req_data[0] = 32'hC0;
    tick(); tick(); #1;
    checks++; if (gnt !== 4'b0001 || data_bus !== 32'hC0) begin failures++; $display("FAIL rstmid_restart act=%b/%h exp=0001/c0", gnt, data_bus); end
    req_valid = 4'b0000;
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_rsvd();
        test_reset_mid();
      end
      begin
        #20000;
        failures++;
        $display("FAIL timeout act=running exp=done");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter sharing the internal 32-bit `data_bus` among `NUM_REQ` requesters. It grants one requester at a time for a burst of up to `MAX_BEATS` beats, muxes that requester's data onto the bus with a valid/ready handshake, and rotates priority after each burst. It sits between the requesting agents and the `internal_if` bus. It guarantees `data_bus` is zero whenever `bus_valid` is low, so the interface's reserved-code check (`data_bus[6:5]` must never be `2'b11`) sees only real beats.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BEATS`, 8: maximum beats per grant, 1..255.
- `clk` input 1: bus clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester beat-valid; also acts as the bus request.
- `req_data` input NUM_REQ x 32: per-requester beat data.
- `req_ready` output NUM_REQ: beat accepted from requester i.
- `gnt` output NUM_REQ: one-hot registered grant.
- `data_bus` output 32: granted data; 0 when `bus_valid`=0.
- `bus_valid` output 1: beat present on `data_bus`.
- `bus_ready` input 1: downstream accepts beat.
- `rsvd_err` output 1: one-cycle pulse, reserved code seen on the granted beat.

## Operation
- Reset values: state IDLE, `gnt`=0, priority pointer `ptr`=0, beat count=0, `bus_valid`=0, `data_bus`=0, `req_ready`=0, `rsvd_err`=0.
- States: IDLE, ARB, XFER.
- IDLE: if any `req_valid`, go to ARB next cycle; otherwise stay.
- ARB:
  - Pick the first asserted `req_valid` at or after index `ptr`, wrapping modulo NUM_REQ. Register `gnt` one-hot, clear the count, go to XFER.
  - If all requests have dropped, go to IDLE with `gnt`=0.
- XFER, with g the granted index:
  - `bus_valid` = `req_valid[g]`; `data_bus` = `req_data[g]` when valid, else 0.
  - `req_ready[g]` = `bus_ready`; all other `req_ready` bits are 0.
  - Beat = `bus_valid` && `bus_ready`. Each beat increments the count.
- Burst end, exit XFER when either:
  - a beat occurs with count == MAX_BEATS-1, or
  - `req_valid[g]`=0 (requester release; no beat that cycle).
- On exit:
  - `ptr` = (g+1) mod NUM_REQ and `gnt` clears.
  - Next state is ARB if any `req_valid` is asserted that cycle, else IDLE.
- A requester that is still valid on a MAX_BEATS exit competes again and loses to any other requester between it and `ptr`.
- Count width is 8 bits; it never wraps because exit happens at MAX_BEATS-1.

## Timing
- Grant latency: `req_valid` rising in IDLE → `gnt` one cycle after ARB. First beat possible in the second cycle after the request.
- Burst-to-burst turnaround: one ARB cycle, with `bus_valid`=0 during ARB.
- `gnt`, `ptr`, count and state are registered. `bus_valid`, `data_bus` and `req_ready` are combinational from registered `gnt` and the inputs.
- A requester dropping `req_valid` while `bus_ready`=0 does not lose a beat; no beat is counted.
- Reset mid-burst: everything asynchronously returns to reset values and no partial beat completes. After `rst_n` rises, arbitration restarts at `ptr`=0.

## Configuration
- `BUS_ARB_RSVD_FILTER_EN` defined:
  - A granted beat with `req_data[g][6:5]`==2'b11 is consumed from the requester (`req_ready[g]`=`bus_ready`) but not forwarded: `bus_valid`=0, `data_bus`=0.
  - `rsvd_err` pulses in the cycle the beat is consumed.
  - The beat still counts toward MAX_BEATS.
- Not defined:
  - Data passes unmodified and `rsvd_err` is tied to 0.
  - The interface assertion is then the only detector.

## Structure
- `bus_arb_pkg`: state enum (IDLE, ARB, XFER), `RSVD_FIELD_HI`=6, `RSVD_FIELD_LO`=5, `RSVD_CODE`=2'b11, bus width constant 32.
- Sub-module `rr_pick`: combinational rotate-priority picker. Inputs are the request vector and `ptr`; outputs are a one-hot winner and its index.

## Test plan
- Single requester: req 1 holds valid for 3 beats then drops, `bus_ready`=1 → `gnt`=4'b0010 in cycle 2, three beats on the bus, then IDLE, `ptr`=2.
- All four continuously valid, MAX_BEATS=8 → grants in order 0,1,2,3,0, each exactly 8 beats, one idle ARB cycle between bursts.
- Backpressure: `bus_ready` low for 5 cycles mid-burst → `data_bus` held stable, count frozen, no grant change.
- Wrap: `ptr`=3 with requests {0,2} → grant 0, then 2.
- Filter on: beat 0x0000_0060 from the granted requester → `bus_valid`=0, `data_bus`=0, one-cycle `rsvd_err` pulse, `req_ready`=1. Filter off: the same beat is driven onto `data_bus` and the interface assertion fires.
- `rst_n` asserted at beat 4 of a burst → all outputs 0 immediately. After release, arbitration restarts with `ptr`=0.
